// File: rtl/hand_accum.sv
// Running baccarat hand accumulator: takes one card per valid strobe and keeps
// the score (pip sum mod MODULUS), the card slots and the dealer status flags.
module hand_accum #(
    parameter int  MAX_CARDS = 3,
    parameter int  MODULUS   = 10,
    localparam int CW        = $clog2(MAX_CARDS + 1)
) (
    input  logic                   slow_clock,
    input  logic                   resetb,
    input  logic                   clear,
    input  logic                   card_valid,
    input  logic [3:0]             card,
    output logic [3:0]             score,
    output logic [CW-1:0]          num_cards,
    output logic [4*MAX_CARDS-1:0] cards,
    output logic                   full,
    output logic                   natural,
    output logic                   reject
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_CARDS - 1);
    localparam logic [CW-1:0] TWO_CARDS = CW'(2);
    localparam logic [4:0]    MOD5      = 5'(MODULUS);
    localparam logic [3:0]    NAT_TH    = 4'(MODULUS - 2);

    state_t        state_reg;
    logic [3:0]    score_reg;
    logic [CW-1:0] num_cards_reg;
    logic          reject_reg;

    logic       legal;
    logic       offer;
    logic       accept;
    logic       rejecting;
    logic [3:0] pip;
    logic [4:0] sum;
    logic [3:0] score_next;

    assign legal     = (card != 4'd0) && (card <= 4'd13);
    assign offer     = card_valid && !clear;
    assign accept    = offer && legal && !full;
    assign rejecting = offer && (!legal || full);

    // Tens and face cards count zero; the sum of two values below MODULUS never
    // needs more than one subtraction to fold back into range.
    assign pip        = (card <= 4'd9) ? card : 4'd0;
    assign sum        = {1'b0, score_reg} + {1'b0, pip};
    assign score_next = (sum >= MOD5) ? 4'(sum - MOD5) : sum[3:0];

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_reg     <= ST_EMPTY;
            score_reg     <= '0;
            num_cards_reg <= '0;
            reject_reg    <= 1'b0;
        end else if (clear) begin
            state_reg     <= ST_EMPTY;
            score_reg     <= '0;
            num_cards_reg <= '0;
            reject_reg    <= 1'b0;
        end else begin
            reject_reg <= rejecting;
            if (accept) begin
                score_reg     <= score_next;
                num_cards_reg <= num_cards_reg + CW'(1);
                state_reg     <= (num_cards_reg == LAST_SLOT) ? ST_FULL : ST_PARTIAL;
            end
        end
    end

    // Each slot captures the card only when the running count points at it.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
            logic [3:0] slot_reg;
            always_ff @(posedge slow_clock or negedge resetb) begin
                if (!resetb) begin
                    slot_reg <= '0;
                end else if (clear) begin
                    slot_reg <= '0;
                end else if (accept && (num_cards_reg == CW'(gi))) begin
                    slot_reg <= card;
                end
            end
            assign cards[4*gi +: 4] = slot_reg;
        end
    endgenerate

    assign score     = score_reg;
    assign num_cards = num_cards_reg;
    assign reject    = reject_reg;
    assign full      = (state_reg == ST_FULL);
    assign natural   = (num_cards_reg == TWO_CARDS) && (score_reg >= NAT_TH);

endmodule
